// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_prog
//  Description : Programmable clock divider with periodic and one-shot modes;
//                registered square-wave output, per-period tick, expiry flag.
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_prog #(
    parameter int CNT_W    = 16,
    parameter int DEF_HALF = 4999
) (
    input  logic             clk_10khz,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] half_in,
    input  logic             mode_in,
    output logic [CNT_W-1:0] half_cur,
    output logic             clk_out,
    output logic             tick,
    output logic             done
);

    localparam logic [CNT_W-1:0] c_def_half     = CNT_W'(DEF_HALF);
    localparam logic             c_mode_oneshot = 1'b1;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic             r_mode;
    logic             r_clk;
    logic             r_tick;
    logic             r_done;
    logic             w_term;

    // Counter only ever reaches r_half, so equality is the sole terminal test.
    assign w_term = (r_cnt == r_half);

    always_ff @(posedge clk_10khz or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_half <= c_def_half;
            r_mode <= 1'b0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
            r_done <= 1'b0;
        end else if (load) begin
            // Load wins over enable and over a coincident terminal count.
            r_half <= half_in;
            r_mode <= mode_in;
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
            r_done <= 1'b0;
        end else if (en && !r_done) begin
            if (w_term) begin
                r_cnt <= '0;
                if (r_mode == c_mode_oneshot) begin
                    r_clk  <= 1'b1;
                    r_tick <= 1'b1;
                    r_done <= 1'b1;
                end else begin
                    r_clk  <= ~r_clk;
                    r_tick <= ~r_clk;
                end
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign half_cur = r_half;
    assign clk_out  = r_clk;
    assign tick     = r_tick;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the half-period counter and the divisor registers.
REQ-002 Parameter DEF_HALF, default 4999, sets the half-period terminal count after reset; 10 kHz in gives 1 Hz out.
REQ-003 clk_10khz  input  1  is the sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  is the reset: asynchronous, active-high.
REQ-005 en  input  1  is the count enable; when low, all state holds.
REQ-006 load  input  1  is a one-cycle request to load a new divisor and restart.
REQ-007 half_in  input  CNT_W  is the new half-period terminal count, sampled when load is high.
REQ-008 mode_in  input  1  selects the run mode, sampled when load is high: 0 = periodic, 1 = one-shot.
REQ-009 half_cur  output  CNT_W  is the active terminal count register.
REQ-010 clk_out  output  1  is the registered divided square wave.
REQ-011 tick  output  1  is a registered single-cycle pulse per period (periodic) or at expiry (one-shot).
REQ-012 done  output  1  is the one-shot expired flag.

Function
REQ-013 The internal counter cnt shall be CNT_W bits wide and shall increment by 1 on each edge where en=1, the block is running, and cnt != half_cur.
REQ-014 When cnt == half_cur with en=1 and the block running, the block shall set cnt to 0 and toggle clk_out on that edge.
REQ-015 In periodic mode, the clk_out period shall be 2*(half_cur+1) clk_10khz cycles of en=1, with 50% duty.
REQ-016 tick shall be 1 for exactly the one cycle in which clk_out has just changed 0->1, and 0 otherwise.
REQ-017 In one-shot mode, the first terminal-count edge after load shall set clk_out=1, tick=1 and done=1, then freeze cnt, with clk_out remaining 1.
REQ-018 While done=1, the counter shall not advance and tick shall stay 0 regardless of en.
REQ-019 load=1 shall, on that edge: set half_cur<=half_in and mode<=mode_in, clear cnt, clk_out, tick and done.
REQ-020 load shall have priority over en and over a coincident terminal count; the terminal count on that edge is discarded.
REQ-021 half_in=0 shall be legal: periodic output then toggles every enabled cycle (period 2), and tick fires every 2 enabled cycles.
REQ-022 A mode_in change without load shall have no effect.
REQ-023 Deasserting en mid-period shall freeze cnt and clk_out, and force tick=0; reasserting en shall resume the count from the frozen value.
REQ-024 The counter shall never exceed half_cur, so there is no wrap beyond 2^CNT_W.
REQ-025 The block shall contain no combinational path from any input to any output.

Reset
REQ-026 rst=1 shall immediately set cnt=0, half_cur=DEF_HALF, mode=periodic, clk_out=0, tick=0 and done=0.
REQ-027 rst asserted mid-period or mid-one-shot shall abort the operation; after release, the block runs periodic at DEF_HALF when en=1.
REQ-028 The first rising edge of clk_out after reset release with en=1 shall occur on the (DEF_HALF+1)th clock edge.

Verification
REQ-029 Reset, en=1, defaults, 25000 cycles -> clk_out rises at edges 5000, 15000 and 25000, and falls at edges 10000 and 20000; tick is high 3 cycles in total.
REQ-030 load with half_in=3, mode_in=0 -> clk_out period is 8 cycles, and tick is spaced exactly 8 cycles apart.
REQ-031 load with half_in=9, mode_in=1 -> on the 10th edge clk_out=1, tick=1 and done=1; over the next 50 cycles tick never repeats, and clk_out stays 1.
REQ-032 en toggled low for 7 cycles mid-period with half_in=3 -> that period stretches to exactly 15 cycles, and no tick occurs while en=0.
REQ-033 load coincident with the terminal count -> clk_out=0, cnt=0, no tick, and the new half_cur is active on the next edge.
REQ-034 rst pulsed asynchronously between edges during one-shot -> outputs clear immediately, half_cur=4999 and done=0.
